// File: rtl/sf_pkg.sv
// ---------------------------------------------------------------------------
// sf_pkg -- shared types for the synchronous-FIFO read side.
//   SF_DATA_W     : default data width
//   sf_rd_state_t : skid-buffer occupancy state (encoding == word count)
//   sf_data_t     : default-width data word
//   sf_level()    : occupancy after this cycle's inflight push and pop
// ---------------------------------------------------------------------------
package sf_pkg;

  localparam int unsigned SF_DATA_W = 8;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } sf_rd_state_t;

  typedef logic [SF_DATA_W-1:0] sf_data_t;

  // Words held next cycle: count + inflight - pop. A pop only happens when
  // count >= 1, so the result never goes negative.
  function automatic logic [2:0] sf_level(input sf_rd_state_t st,
                                          input logic         inflight,
                                          input logic         pop);
    return {1'b0, st} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/sf_rd_skid.sv
// ---------------------------------------------------------------------------
// sf_rd_skid -- 2-entry push/pop register buffer.
//   Entry 0 is the head and drives dout_o directly, so the head word stays put
//   until it is popped. Entry 1 only holds a word in state S_TWO.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   push_i     : write din_i at the tail this cycle
//   pop_i      : drop the head entry this cycle
//   din_i      : tail write data
//   dout_o     : head entry (reset value 0)
//   state_o    : occupancy S_EMPTY / S_ONE / S_TWO
// ---------------------------------------------------------------------------
module sf_rd_skid
  import sf_pkg::*;
#(
  parameter int unsigned DATA_W = SF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output sf_rd_state_t      state_o
);

  logic [DATA_W-1:0] ent0_q, ent0_d;
  logic [DATA_W-1:0] ent1_q, ent1_d;
  sf_rd_state_t      state_q, state_d;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: begin
        if (push_i) begin
          ent0_d  = din_i;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        unique case ({push_i, pop_i})
          2'b10: begin
            ent1_d  = din_i;
            state_d = S_TWO;
          end
          2'b01: state_d = S_EMPTY;
          // Simultaneous push and pop: the new word becomes the head.
          2'b11: ent0_d = din_i;
          default: ;
        endcase
      end
      S_TWO: begin
        if (pop_i) begin
          ent0_d  = ent1_q;
          state_d = S_ONE;
          if (push_i) begin
            ent1_d  = din_i;
            state_d = S_TWO;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      state_q <= S_EMPTY;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      state_q <= state_d;
    end
  end

  assign dout_o  = ent0_q;
  assign state_o = state_q;

  // A push into a full buffer without a pop would lose a word.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == S_TWO && push_i && !pop_i));

endmodule

// File: rtl/sf_fifo_reader.sv
// ---------------------------------------------------------------------------
// sf_fifo_reader -- read-side consumer for the synchronous FIFO.
//   Pops the FIFO (1-cycle read latency) and re-presents the words as a
//   valid/ready stream through a 2-entry skid buffer, sustaining 1 word/cycle
//   while m_ready is high.
// Ports:
//   clk, rst_n    : clock, async active-low reset (release synchronised to clk)
//   fifo_empty    : FIFO empty flag
//   fifo_data_out : FIFO read data, valid the cycle after fifo_r_en
//   fifo_r_en     : FIFO pop request
//   m_valid       : output word available
//   m_ready       : downstream accepts m_data this cycle
//   m_data        : output word (skid-buffer head)
//   rd_count      : words delivered, saturating      (SF_RD_STATS_EN only)
//   stall_count   : cycles with m_valid && !m_ready  (SF_RD_STATS_EN only)
// Configuration macro: SF_RD_STATS_EN adds the STAT_W parameter and the two
// saturating statistics counters; core behaviour is unchanged.
// ---------------------------------------------------------------------------
module sf_fifo_reader
  import sf_pkg::*;
#(
  parameter int unsigned DATA_W = SF_DATA_W
`ifdef SF_RD_STATS_EN
  ,
  parameter int unsigned STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_r_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef SF_RD_STATS_EN
  ,
  output logic [STAT_W-1:0] rd_count,
  output logic [STAT_W-1:0] stall_count
`endif
);

  sf_rd_state_t state;
  logic         inflight_q;
  logic         run_q;
  logic         pop;
  logic [2:0]   level;

  // run_q rises on the first clock after reset release, so fifo_r_en (which is
  // combinational) stays low throughout reset and during the release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= fifo_r_en;
    end
  end

  assign m_valid = (state != S_EMPTY);
  assign pop     = m_valid && m_ready;

  // Credit check: only request when the word will have a slot to land in.
  assign level     = sf_level(state, inflight_q, pop);
  assign fifo_r_en = run_q && !fifo_empty && (level < 3'd2);

  sf_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .din_i   (fifo_data_out),
    .dout_o  (m_data),
    .state_o (state)
  );

  // The credit rule keeps count + inflight <= 2.
  a_two_plus_inflight : assert property (@(posedge clk) disable iff (!rst_n)
    !(state == S_TWO && inflight_q));

  a_no_underflow_read : assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_r_en && fifo_empty));

`ifdef SF_RD_STATS_EN
  logic [STAT_W-1:0] rd_count_q;
  logic [STAT_W-1:0] stall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      if (pop && rd_count_q != '1)
        rd_count_q <= rd_count_q + STAT_W'(1);
      if (m_valid && !m_ready && stall_count_q != '1)
        stall_count_q <= stall_count_q + STAT_W'(1);
    end
  end

  assign rd_count    = rd_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_sf_fifo_reader.sv
// ---------------------------------------------------------------------------
// tb_sf_fifo_reader -- scoreboard bench for sf_fifo_reader.
//   A queue-based FIFO model feeds the DUT; every word written into the model
//   is also pushed onto the expected queue, and a negedge monitor pops and
//   compares on every m_valid && m_ready handshake.
// ---------------------------------------------------------------------------
module tb_sf_fifo_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data_out = '0;
  logic       fifo_r_en;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
`ifdef SF_RD_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] stall_count;
`endif

  sf_fifo_reader #(
    .DATA_W (8)
`ifdef SF_RD_STATS_EN
    ,
    .STAT_W (16)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_r_en     (fifo_r_en),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data)
`ifdef SF_RD_STATS_EN
    ,
    .rd_count      (rd_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         delivered = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         hs_cyc[$];
  logic       ren_s = 1'b0;
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data = '0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous FIFO model: data appears the cycle after the pop request.
  always @(posedge clk) begin
    if (ren_s && fifo_q.size() > 0)
      fifo_data_out <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    ren_s = fifo_r_en;
    if (fifo_r_en)
      check("no_underflow_read", {31'd0, fifo_empty}, 32'd0);
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_data", {24'd0, m_data}, {24'd0, prev_data});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", m_data);
        end else begin
          check("data_order", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        end
        delivered++;
        hs_cyc.push_back(cyc);
      end
      hold_prev = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r_cyc;
    int v_cyc;
    int pulses;
    int d0;

    // Reset with words already waiting in the FIFO.
    push(8'h11); push(8'h22); push(8'h33);
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_r_en", {31'd0, fifo_r_en}, 32'd0);

    // 1: streaming with m_ready held high.
    hs_cyc.delete();
    r_cyc = -1;
    v_cyc = -1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_r_en && r_cyc < 0) r_cyc = cyc;
      if (m_valid && v_cyc < 0) v_cyc = cyc;
    end
    check("t1_r_en_seen", {31'd0, r_cyc >= 0}, 32'd1);
    check("t1_latency", v_cyc - r_cyc, 32'd2);
    check("t1_words", hs_cyc.size(), 32'd3);
    check("t1_back_to_back", (hs_cyc.size() == 3) ? hs_cyc[2] - hs_cyc[0] : -1, 32'd2);
    check("t1_drained", exp_q.size(), 32'd0);

    // 2: back-pressure with 8 words queued.
    tick();
    m_ready = 1'b0;
    for (int w = 0; w < 8; w++) push(8'h40 + 8'(w));
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_r_en) pulses++;
    end
    check("t2_r_en_pulses", pulses, 32'd2);
    check("t2_m_valid", {31'd0, m_valid}, 32'd1);
    check("t2_head", {24'd0, m_data}, 32'h40);
    tick();
    m_ready = 1'b1;
    drain("t2_drained", 40);

    // 3: FIFO stays empty.
    for (int i = 0; i < 20; i++) begin
      tick();
      m_ready = (i % 2 == 0);
      @(negedge clk);
      check("t3_r_en", {31'd0, fifo_r_en}, 32'd0);
      check("t3_m_valid", {31'd0, m_valid}, 32'd0);
    end

    // 4: m_ready toggling, 16 words.
    tick();
    d0 = delivered;
    for (int w = 0; w < 16; w++) push(8'(w));
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    check("t4_drained", exp_q.size(), 32'd0);
    check("t4_count", delivered - d0, 32'd16);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_no_extra", {31'd0, m_valid}, 32'd0);
    end

    // 5: reset while the buffer is full.
    tick();
    m_ready = 1'b0;
    for (int w = 0; w < 5; w++) push(8'h50 + 8'(w));
    repeat (4) tick();
    check("t5_full_before_rst", {31'd0, m_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("t5_rst_m_data", {24'd0, m_data}, 32'd0);
    check("t5_rst_r_en", {31'd0, fifo_r_en}, 32'd0);
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    d0 = delivered;
    push(8'hA5);
    m_ready = 1'b1;
    drain("t5_drained", 20);
    check("t5_count", delivered - d0, 32'd1);

`ifdef SF_RD_STATS_EN
    // 6: statistics counters.
    tick();
    rst_n = 1'b0;
    tick();
    check("t6_rst_rd_count", {16'd0, rd_count}, 32'd0);
    check("t6_rst_stall_count", {16'd0, stall_count}, 32'd0);
    rst_n = 1'b1;
    m_ready = 1'b0;
    for (int w = 0; w < 5; w++) push(8'h60 + 8'(w));
    begin
      int k = 0;
      @(negedge clk);
      while (!m_valid && k < 10) begin
        @(negedge clk);
        k++;
      end
    end
    check("t6_valid_seen", {31'd0, m_valid}, 32'd1);
    // Three stall cycles: this one and the next two.
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); #1 m_ready = 1'b1;
    drain("t6_drained", 30);
    repeat (3) tick();
    check("t6_rd_count", {16'd0, rd_count}, 32'd5);
    check("t6_stall_count", {16'd0, stall_count}, 32'd3);
    m_ready = 1'b0;
    push(8'h77);
    repeat (65545) tick();
    check("t6_stall_saturate", {16'd0, stall_count}, 32'hFFFF);
    check("t6_rd_count_hold", {16'd0, rd_count}, 32'd5);
    m_ready = 1'b1;
    drain("t6_sat_drained", 20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
